// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, frame marker, length width.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

endpackage

// File: rtl/inst_mem_loader_cksum.sv
// XOR accumulator over payload bytes; result registered, updates one cycle after en.
// Clear has priority over enable.
module loader_cksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader: SYNC, LEN (words, LE), 4*LEN payload bytes, XOR checksum.
// Writes are registered one cycle after acceptance; ready depends on state only (low in DONE/ERR).
module inst_mem_loader #(
  parameter int                    Address_Width = 32,
  parameter int                    Data_Width    = 8,
  parameter int unsigned           Mem_Depth     = 1024,
  parameter logic [Data_Width-1:0] SYNC_BYTE     = inst_mem_loader_pkg::SYNC_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [Data_Width-1:0]    i_Byte_Data,
  input  logic                     i_Byte_Valid,
  output logic                     o_Byte_Ready,
  input  logic                     i_Start,
  output logic                     o_Wr_En,
  output logic [Address_Width-1:0] o_Wr_Addr,
  output logic [Data_Width-1:0]    o_Wr_Data,
  output logic                     o_Core_Rst_n,
  output logic                     o_Done,
  output logic                     o_Error
);

  import inst_mem_loader_pkg::*;

  localparam int HALF_W = LEN_W / 2;
  localparam int CNT_W  = LEN_W + 2;

  state_t                   state_q;
  logic [HALF_W-1:0]        len_lo_q;
  logic [LEN_W-1:0]         len_q;
  logic [Address_Width-1:0] byte_cnt_q;
  logic [Data_Width-1:0]    cksum;

  logic                     beat;
  logic                     rearm;
  logic [LEN_W-1:0]         len_in;
  logic [CNT_W-1:0]         len_bytes_in;
  logic                     oversize;
  logic [CNT_W-1:0]         byte_last;
  logic                     cksum_clr;
  logic                     cksum_en;

  assign o_Byte_Ready = (state_q != DONE) && (state_q != ERR);
  assign beat         = i_Byte_Valid && o_Byte_Ready;
  assign rearm        = i_Start && ((state_q == DONE) || (state_q == ERR));

  // Length is validated in bytes, as it arrives, so byte_cnt can never exceed Mem_Depth.
  assign len_in       = {i_Byte_Data[HALF_W-1:0], len_lo_q};
  assign len_bytes_in = {len_in, 2'b00};
  assign oversize     = 32'(len_bytes_in) > Mem_Depth;
  assign byte_last    = {len_q, 2'b00} - CNT_W'(1);

  assign cksum_clr = ((state_q == LEN_HI) && beat) || rearm;
  assign cksum_en  = (state_q == DATA) && beat;

  loader_cksum #(
    .W (Data_Width)
  ) u_cksum (
    .clk (clk),
    .rst (rst),
    .clr (cksum_clr),
    .en  (cksum_en),
    .din (i_Byte_Data),
    .sum (cksum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_SYNC;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= '0;
      o_Core_Rst_n <= 1'b0;
      o_Done       <= 1'b0;
      o_Error      <= 1'b0;
    end else begin
      o_Wr_En <= 1'b0;
      case (state_q)
        WAIT_SYNC: begin
          if (beat && (i_Byte_Data == SYNC_BYTE)) state_q <= LEN_LO;
        end
        LEN_LO: begin
          if (beat) begin
            len_lo_q <= i_Byte_Data[HALF_W-1:0];
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (beat) begin
            len_q      <= len_in;
            byte_cnt_q <= '0;
            if (oversize) begin
              state_q <= ERR;
              o_Error <= 1'b1;
            end else if (len_in == '0) begin
              state_q <= CHECK;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (beat) begin
            o_Wr_En    <= 1'b1;
            o_Wr_Addr  <= byte_cnt_q;
            o_Wr_Data  <= i_Byte_Data;
            byte_cnt_q <= byte_cnt_q + Address_Width'(1);
            if (byte_cnt_q == Address_Width'(byte_last)) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (beat) begin
            if (i_Byte_Data == cksum) begin
              state_q      <= DONE;
              o_Done       <= 1'b1;
              o_Core_Rst_n <= 1'b1;
            end else begin
              state_q <= ERR;
              o_Error <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (i_Start) begin
            state_q      <= WAIT_SYNC;
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            o_Done       <= 1'b0;
            o_Error      <= 1'b0;
            o_Core_Rst_n <= 1'b0;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboarded bench: a frame-level reference model queues expected writes and final status,
// a negedge monitor pops and compares every write the loader issues.
module tb_inst_mem_loader;

  localparam int MEM_DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [7:0]  i_Byte_Data;
  logic        i_Byte_Valid;
  logic        o_Byte_Ready;
  logic        i_Start;
  logic        o_Wr_En;
  logic [31:0] o_Wr_Addr;
  logic [7:0]  o_Wr_Data;
  logic        o_Core_Rst_n;
  logic        o_Done;
  logic        o_Error;

  int vectors;
  int miscompares;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  inst_mem_loader #(
    .Address_Width (32),
    .Data_Width    (8),
    .Mem_Depth     (MEM_DEPTH),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_Byte_Data  (i_Byte_Data),
    .i_Byte_Valid (i_Byte_Valid),
    .o_Byte_Ready (o_Byte_Ready),
    .i_Start      (i_Start),
    .o_Wr_En      (o_Wr_En),
    .o_Wr_Addr    (o_Wr_Addr),
    .o_Wr_Data    (o_Wr_Data),
    .o_Core_Rst_n (o_Core_Rst_n),
    .o_Done       (o_Done),
    .o_Error      (o_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst && o_Wr_En) begin
      if (exp_addr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", o_Wr_Addr, o_Wr_Data);
      end else begin
        chk("wr_addr", o_Wr_Addr, exp_addr_q.pop_front());
        chk("wr_data", 32'(o_Wr_Data), 32'(exp_data_q.pop_front()));
      end
    end
  end

  // Reference model: parse one frame from stim_q by the framing rules.
  task automatic model_frame(output bit exp_done, output bit exp_err);
    int         i;
    int         len;
    logic [7:0] x;
    i        = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (i < stim_q.size() && stim_q[i] != 8'hA5) i++;
    len = int'({stim_q[i+2], stim_q[i+1]});
    if (4 * len > MEM_DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < 4 * len; k++) begin
      exp_addr_q.push_back(32'(k));
      exp_data_q.push_back(stim_q[i+3+k]);
      x = x ^ stim_q[i+3+k];
    end
    if (stim_q[i+3+4*len] == x) exp_done = 1'b1;
    else                        exp_err  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    i_Byte_Valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_Byte_Data  = b;
    i_Byte_Valid = 1'b1;
    t = 0;
    while (!o_Byte_Ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got ready=0 for 20 cycles, expected ready=1");
    end
    @(posedge clk);
    #1;
    i_Byte_Valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_lo, input int gap_hi);
    bit d, e;
    model_frame(d, e);
    for (int j = 0; j < stim_q.size() - 1; j++)
      send_byte(stim_q[j], int'($urandom_range(gap_hi, gap_lo)));
    chk({tag, "_done_before_last"}, 32'(o_Done), 32'(0));
    chk({tag, "_err_before_last"}, 32'(o_Error), 32'(0));
    send_byte(stim_q[stim_q.size()-1], int'($urandom_range(gap_hi, gap_lo)));
    chk({tag, "_done"}, 32'(o_Done), 32'(d));
    chk({tag, "_error"}, 32'(o_Error), 32'(e));
    chk({tag, "_core_rst_n"}, 32'(o_Core_Rst_n), 32'(d));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_ready"}, 32'(o_Byte_Ready), 32'(!(d || e)));
    chk({tag, "_writes_pending"}, 32'(exp_addr_q.size()), 32'(0));
  endtask

  task automatic rearm(input string tag);
    i_Start = 1'b1;
    @(posedge clk);
    #1;
    i_Start = 1'b0;
    chk({tag, "_rearm_done"}, 32'(o_Done), 32'(0));
    chk({tag, "_rearm_error"}, 32'(o_Error), 32'(0));
    chk({tag, "_rearm_core_rst_n"}, 32'(o_Core_Rst_n), 32'(0));
    chk({tag, "_rearm_ready"}, 32'(o_Byte_Ready), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(o_Wr_En), 32'(0));
    chk({tag, "_wr_addr"}, o_Wr_Addr, 32'(0));
    chk({tag, "_wr_data"}, 32'(o_Wr_Data), 32'(0));
    chk({tag, "_core_rst_n"}, 32'(o_Core_Rst_n), 32'(0));
    chk({tag, "_done"}, 32'(o_Done), 32'(0));
    chk({tag, "_error"}, 32'(o_Error), 32'(0));
    chk({tag, "_ready"}, 32'(o_Byte_Ready), 32'(1));
  endtask

  initial begin
    int         len;
    logic [7:0] x;
    logic [7:0] g;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    i_Byte_Data  = 8'h00;
    i_Byte_Valid = 1'b0;
    i_Start      = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Nominal LEN=2; the payload XORs to 0x90.
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("nominal", 0, 0);
    rearm("nominal");

    stim_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_frame("bubbles", 3, 3);
    rearm("bubbles");

    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("bad_cksum", 0, 1);
    rearm("bad_cksum");

    stim_q = '{8'hA5, 8'h01, 8'h01};
    run_frame("oversize", 0, 1);
    rearm("oversize");

    stim_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero_len", 0, 0);
    rearm("zero_len");

    // Largest legal frame: fills the memory exactly up to address MEM_DEPTH-1.
    stim_q = '{8'hA5, 8'h00, 8'h01};
    x = 8'h00;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      g = 8'($urandom_range(255, 0));
      stim_q.push_back(g);
      x = x ^ g;
    end
    stim_q.push_back(x);
    run_frame("max_len", 0, 0);
    rearm("max_len");

    // Reset in the middle of the payload.
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    exp_addr_q.push_back(32'd0);
    exp_data_q.push_back(8'h11);
    exp_addr_q.push_back(32'd1);
    exp_data_q.push_back(8'h22);
    foreach (stim_q[j]) send_byte(stim_q[j], 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    chk("mid_reset_writes_pending", 32'(exp_addr_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("after_reset", 0, 1);
    rearm("after_reset");

    for (int n = 0; n < 25; n++) begin
      stim_q.delete();
      repeat ($urandom_range(3, 0)) begin
        g = 8'($urandom_range(255, 0));
        stim_q.push_back((g == 8'hA5) ? 8'h00 : g);
      end
      stim_q.push_back(8'hA5);
      if ($urandom_range(5, 0) == 0) begin
        len = 257 + int'($urandom_range(300, 0));
        stim_q.push_back(8'(len));
        stim_q.push_back(8'(len >> 8));
      end else begin
        len = int'($urandom_range(6, 0));
        stim_q.push_back(8'(len));
        stim_q.push_back(8'h00);
        x = 8'h00;
        for (int k = 0; k < 4 * len; k++) begin
          g = 8'($urandom_range(255, 0));
          stim_q.push_back(g);
          x = x ^ g;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        stim_q.push_back(x);
      end
      run_frame($sformatf("rand%0d", n), 0, 2);
      rearm($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
